// File: rtl/fp_pkg.sv
// Shared definitions for floating-point unit arbiters: format constants,
// sequencer state encoding and the round-robin picker.
package fp_pkg;

  localparam int FP_W  = 32;
  localparam int MAX_N = 8;
  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    OPA   = 3'd2,
    OPB   = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } fpState_t;

  // First set bit at or after ptr, wrapping. Unused upper request bits must be
  // zero, which makes a modulo-8 wrap equivalent to a modulo-N wrap.
  function automatic logic [2:0] rr_pick(input logic [MAX_N-1:0] req,
                                         input logic [2:0] ptr);
    logic [2:0] idx;
    rr_pick = ptr;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/fpmult_arbiter.sv
// Round-robin arbiter and sequencer sharing one serial-operand FP multiplier
// among N requesters; all outputs are registered Moore outputs.
module fpmult_arbiter
  import fp_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [FP_W*N-1:0] opA,
  input  logic [FP_W*N-1:0] opB,
  output logic [N-1:0]      done,
  output logic [FP_W-1:0]   result,
  output logic              err,
  output logic              busy,
  output logic [FP_W-1:0]   mul_inBus,
  output logic              mul_startFP,
  input  logic [FP_W-1:0]   mul_resBus,
  input  logic              mul_doneFP,
  output fpState_t          stateDbg
);

  // Requester handshake: req[i] is held with stable operands until the
  // single-cycle done[i] pulse; the requester must drop req[i] the cycle after.
  localparam logic [2:0]  LAST_IDX = 3'(N - 1);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  fpState_t        state, stateNext;
  logic [2:0]      ptr, ptrNext, gnt, gntNext;
  logic [15:0]     cnt, cntNext;
  logic            flag, flagNext;
  logic [MAX_N-1:0] reqWide;
  logic [FP_W-1:0] resultNext, busNext;
  logic [N-1:0]    doneNext;
  logic            startNext, errNext, busyNext;

  always_comb begin
    reqWide = '0;
    reqWide[N-1:0] = req;
  end

  always_comb begin
    stateNext  = state;
    gntNext    = gnt;
    ptrNext    = ptr;
    cntNext    = cnt;
    flagNext   = flag;
    resultNext = result;

    case (state)
      IDLE: begin
        if (|req) begin
          gntNext   = rr_pick(reqWide, ptr);
          stateNext = START;
        end
      end
      START: stateNext = OPA;
      OPA:   stateNext = OPB;
      OPB: begin
        cntNext   = '0;
        stateNext = WAIT;
      end
      WAIT: begin
        // A done arriving on the timeout cycle still wins over the timeout.
        if (mul_doneFP) begin
          resultNext = mul_resBus;
          stateNext  = RESP;
        end else begin
          cntNext = cnt + 16'd1;
          if (cnt == CNT_LAST) begin
            resultNext = QNAN;
            flagNext   = 1'b1;
            stateNext  = RESP;
          end
        end
      end
      RESP: begin
        ptrNext   = (gnt == LAST_IDX) ? 3'd0 : gnt + 3'd1;
        flagNext  = 1'b0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    // Output values for the state being entered, registered alongside it.
    startNext = 1'b0;
    busNext   = '0;
    doneNext  = '0;
    errNext   = 1'b0;
    busyNext  = (stateNext != IDLE);
    case (stateNext)
      START: startNext = 1'b1;
      OPA: begin
        for (int i = 0; i < N; i++)
          if (gnt == 3'(i)) busNext = opA[i*FP_W +: FP_W];
      end
      OPB: begin
        for (int i = 0; i < N; i++)
          if (gnt == 3'(i)) busNext = opB[i*FP_W +: FP_W];
      end
      RESP: begin
        for (int i = 0; i < N; i++) doneNext[i] = (gnt == 3'(i));
        errNext = flagNext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt         <= '0;
      cnt         <= '0;
      flag        <= 1'b0;
      result      <= '0;
      done        <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      mul_inBus   <= '0;
      mul_startFP <= 1'b0;
    end else begin
      state       <= stateNext;
      ptr         <= ptrNext;
      gnt         <= gntNext;
      cnt         <= cntNext;
      flag        <= flagNext;
      result      <= resultNext;
      done        <= doneNext;
      err         <= errNext;
      busy        <= busyNext;
      mul_inBus   <= busNext;
      mul_startFP <= startNext;
    end
  end

  assign stateDbg = state;

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Self-checking bench for fpmult_arbiter with a behavioural multiplier stub
// and a transaction-level round-robin reference model.
module tb_fpmult_arbiter;
  import fp_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    reqV;
  logic [32*N-1:0] opAv, opBv;
  logic [N-1:0]    done;
  logic [31:0]     result;
  logic            err, busy;
  logic [31:0]     mul_inBus;
  logic            mul_startFP;
  logic [31:0]     mul_resBus;
  logic            mul_doneFP;
  fpState_t        stateDbg;

  logic [31:0] laneA [N];
  logic [31:0] laneB [N];
  logic [31:0] exp_q [$];

  int nTests = 0;
  int nFail  = 0;
  int ptrModel = 0;
  int lastGnt = -1;
  int reraise = -1;
  bit autoRe = 1'b0;
  logic [31:0] lastResult;

  fpmult_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(reqV), .opA(opAv), .opB(opBv),
    .done(done), .result(result), .err(err), .busy(busy),
    .mul_inBus(mul_inBus), .mul_startFP(mul_startFP),
    .mul_resBus(mul_resBus), .mul_doneFP(mul_doneFP), .stateDbg(stateDbg)
  );

  // clock / operand packing
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      opAv[32*i +: 32] = laneA[i];
      opBv[32*i +: 32] = laneB[i];
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expv);
    nTests++;
    if (got !== expv) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-precision multiply for normal operands, round to nearest even.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [23:0] m;
    logic        g, st;
    int          e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; e++;
    end else begin
      m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = 24'd0; e++;
    end
    return {a[31] ^ b[31], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] randOp();
    logic [31:0] s, e, m;
    s = $urandom_range(0, 1);
    e = $urandom_range(110, 140);
    m = $urandom;
    return {s[0], e[7:0], m[22:0]};
  endfunction

  function automatic int modelPick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One full transaction starting from an IDLE cycle with reqV already set.
  // lat: WAIT cycle on which the stub answers (0 = never). dropAt: WAIT cycle
  // on which the granted requester drops its request (0 = never).
  task automatic runTxn(input int lat, input int dropAt);
    int          g;
    logic [31:0] capA, capB, expRes;
    logic        expErr;
    logic [N-1:0] expDone;
    g = modelPick(reqV, ptrModel);
    checkVal("req_present", 32'(g >= 0), 32'd1);
    if (g < 0) return;
    if (lat >= 1 && lat <= TO) begin
      expRes = fmul(laneA[g], laneB[g]); expErr = 1'b0;
    end else begin
      expRes = QNAN; expErr = 1'b1;
    end
    exp_q.push_back(expRes);

    tick();
    mul_doneFP = 1'($urandom_range(0, 1));
    mul_resBus = $urandom;
    checkVal("start_pulse", 32'(mul_startFP), 32'd1);
    checkVal("start_bus", mul_inBus, 32'd0);
    checkVal("busy_start", 32'(busy), 32'd1);
    if (reraise >= 0) begin
      reqV[reraise] = 1'b1;
      reraise = -1;
    end

    tick();
    mul_doneFP = 1'($urandom_range(0, 1));
    checkVal("opA_bus", mul_inBus, laneA[g]);
    checkVal("opA_start", 32'(mul_startFP), 32'd0);
    capA = mul_inBus;

    tick();
    mul_doneFP = 1'($urandom_range(0, 1));
    checkVal("opB_bus", mul_inBus, laneB[g]);
    capB = mul_inBus;

    for (int k = 1; k <= TO; k++) begin
      tick();
      checkVal("wait_bus", mul_inBus, 32'd0);
      checkVal("wait_done", 32'(done), 32'd0);
      if (k == dropAt) reqV[g] = 1'b0;
      if (k == lat) begin
        mul_doneFP = 1'b1;
        mul_resBus = fmul(capA, capB);
        break;
      end
      mul_doneFP = 1'b0;
      mul_resBus = $urandom;
    end

    tick();
    mul_doneFP = 1'($urandom_range(0, 1));
    mul_resBus = $urandom;
    expDone = '0;
    expDone[g] = 1'b1;
    expRes = exp_q.pop_front();
    checkVal("done_vec", 32'(done), 32'(expDone));
    checkVal("err_flag", 32'(err), 32'(expErr));
    checkVal("result", result, expRes);
    checkVal("busy_resp", 32'(busy), 32'd1);
    lastGnt = -1;
    for (int i = 0; i < N; i++) if (done[i]) lastGnt = i;
    lastResult = result;
    reqV[g] = 1'b0;
    ptrModel = (g + 1) % N;
    if (autoRe) reraise = g;

    tick();
    mul_doneFP = 1'b0;
    checkVal("idle_done", 32'(done), 32'd0);
    checkVal("idle_busy", 32'(busy), 32'd0);
    checkVal("idle_err", 32'(err), 32'd0);
    checkVal("result_held", result, expRes);
    checkVal("idle_state", 32'(stateDbg), 32'(IDLE));
  endtask

  initial begin
    int lat, drop, pick;
    logic [31:0] held;

    // reset
    rst = 1'b0; reqV = '0; mul_doneFP = 1'b0; mul_resBus = '0;
    for (int i = 0; i < N; i++) begin
      laneA[i] = randOp(); laneB[i] = randOp();
    end
    tick(); tick(); tick();
    checkVal("rst_done", 32'(done), 32'd0);
    checkVal("rst_result", result, 32'd0);
    checkVal("rst_err", 32'(err), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_bus", mul_inBus, 32'd0);
    checkVal("rst_start", 32'(mul_startFP), 32'd0);
    checkVal("rst_state", 32'(stateDbg), 32'(IDLE));
    rst = 1'b1;
    tick();

    // single request 3.0 x 2.5
    laneA[0] = 32'h4040_0000; laneB[0] = 32'h4020_0000;
    reqV = 4'b0001;
    runTxn(3, 0);
    checkVal("single_7p5", lastResult, 32'h40F0_0000);

    // timeout on lane 3 (stub never answers)
    laneA[3] = randOp(); laneB[3] = randOp();
    reqV = 4'b1000;
    runTxn(0, 0);
    checkVal("timeout_qnan", lastResult, QNAN);

    // round-robin with every lane requesting
    for (int i = 0; i < N; i++) begin
      laneA[i] = randOp(); laneB[i] = randOp();
    end
    laneA[2] = 32'h412B_3333; laneB[2] = 32'h4020_0000;
    reqV = 4'b1111;
    autoRe = 1'b1;
    for (int k = 0; k < 5; k++) begin
      runTxn($urandom_range(1, 6), 0);
      checkVal("rr_order", 32'(lastGnt), 32'(k % N));
      if (k == 2) checkVal("rr_lane2", lastResult, 32'h41D6_0000);
    end
    autoRe = 1'b0; reraise = -1; reqV = '0;

    // done on the final timeout cycle counts as a real result
    laneA[0] = randOp(); laneB[0] = randOp();
    reqV = 4'b0001;
    runTxn(TO, 0);

    // requester drops during WAIT, still receives its pulse
    laneA[1] = randOp(); laneB[1] = randOp();
    reqV = 4'b0010;
    runTxn(5, 2);

    // stray multiplier done while idle
    held = lastResult;
    for (int k = 0; k < 4; k++) begin
      mul_doneFP = 1'($urandom_range(0, 1));
      mul_resBus = $urandom;
      tick();
      checkVal("stray_done", 32'(done), 32'd0);
      checkVal("stray_busy", 32'(busy), 32'd0);
      checkVal("stray_result", result, held);
    end
    mul_doneFP = 1'b0;
    tick();

    // reset in the middle of WAIT; pending requests re-arbitrate from 0
    laneA[1] = randOp(); laneB[1] = randOp();
    laneA[3] = randOp(); laneB[3] = randOp();
    reqV = 4'b1010;
    pick = modelPick(reqV, ptrModel);
    tick();
    checkVal("pre_rst_start", 32'(mul_startFP), 32'd1);
    tick();
    checkVal("pre_rst_opA", mul_inBus, laneA[pick]);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    checkVal("mid_rst_done", 32'(done), 32'd0);
    checkVal("mid_rst_busy", 32'(busy), 32'd0);
    checkVal("mid_rst_result", result, 32'd0);
    checkVal("mid_rst_bus", mul_inBus, 32'd0);
    checkVal("mid_rst_state", 32'(stateDbg), 32'(IDLE));
    rst = 1'b1;
    ptrModel = 0;
    runTxn(3, 0);
    checkVal("post_rst_gnt", 32'(lastGnt), 32'd1);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!reqV[i] && i != lastGnt && $urandom_range(0, 2) == 0) begin
          laneA[i] = randOp(); laneB[i] = randOp(); reqV[i] = 1'b1;
        end
      end
      if (reqV == '0) begin
        pick = (lastGnt + 1 + int'($urandom_range(0, N - 2))) % N;
        laneA[pick] = randOp(); laneB[pick] = randOp(); reqV[pick] = 1'b1;
      end
      lat  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
      drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      runTxn(lat, drop);
    end

    checkVal("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
